// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants for the five-digit seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int NUM_DIGITS = 5;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg
// Description : Nibble plus blank flag to active-low seven-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_DASH;
        if (blank_i) begin
            seg_n_o = SEG_BLANK;
        end else begin
            case (nibble_i)
                4'd0:    seg_n_o = SEG_0;
                4'd1:    seg_n_o = SEG_1;
                4'd2:    seg_n_o = SEG_2;
                4'd3:    seg_n_o = SEG_3;
                4'd4:    seg_n_o = SEG_4;
                4'd5:    seg_n_o = SEG_5;
                4'd6:    seg_n_o = SEG_6;
                4'd7:    seg_n_o = SEG_7;
                4'd8:    seg_n_o = SEG_8;
                4'd9:    seg_n_o = SEG_9;
                default: seg_n_o = SEG_DASH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scanner
// Description : Five-digit multiplexed seven-segment driver with blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] bcd_in,
    input  logic        load,
    input  logic        blank_zeros,
    output logic [6:0]  seg_n,
    output logic [4:0]  an_n,
    output logic        frame_done
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]      LAST_DIG = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [19:0]      value_q, value_d;
    logic             wrap_q, wrap_d;
    logic [6:0]       seg_n_q;
    logic [4:0]       an_n_q;
    logic             frame_done_q;

    logic                  tick;
    logic [NUM_DIGITS-1:0] nz;
    logic [NUM_DIGITS-1:0] suffix_nz;
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic [6:0]            cur_seg_n;

    assign tick = (div_cnt_q == CNT_MAX);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nz
        assign nz[k] = |value_q[4*k +: 4];
    end

    // suffix_nz[k]: some nibble at position k or above is non-zero
    always_comb begin
        suffix_nz = '0;
        suffix_nz[NUM_DIGITS-1] = nz[NUM_DIGITS-1];
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            suffix_nz[k] = nz[k] | suffix_nz[k+1];
        end
    end

    always_comb begin
        cur_nibble = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_q == 3'(k)) begin
                cur_nibble = value_q[4*k +: 4];
            end
        end
        cur_blank = blank_zeros && (digit_idx_q != 3'd0) && !suffix_nz[digit_idx_q];
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble_i (cur_nibble),
        .blank_i  (cur_blank),
        .seg_n_o  (cur_seg_n)
    );

    // wrap_q marks that digit 0 has just been selected internally; delaying it
    // once more lines the pulse up with digit 0's first output cycle.
    always_comb begin
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (tick) begin
            digit_idx_d = (digit_idx_q == LAST_DIG) ? 3'd0 : digit_idx_q + 3'd1;
        end
        value_d = load ? bcd_in : value_q;
        wrap_d  = tick && (digit_idx_q == LAST_DIG);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= 3'd0;
            value_q      <= 20'd0;
            wrap_q       <= 1'b0;
            seg_n_q      <= SEG_BLANK;
            an_n_q       <= 5'b11111;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            value_q      <= value_d;
            wrap_q       <= wrap_d;
            seg_n_q      <= cur_seg_n;
            an_n_q       <= ~(5'b00001 << digit_idx_q);
            frame_done_q <= wrap_q;
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_scanner
// Description : Self-checking bench with a frame-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 5 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] bcd_in;
    logic        load;
    logic        blank_zeros;
    logic [6:0]  seg_n;
    logic [4:0]  an_n;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: cyc = index of the next non-reset edge since release
    logic [19:0] value_m;
    int          cyc;
    logic [6:0]  exp_seg;
    logic [4:0]  exp_an;
    logic        exp_fd;

    bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .bcd_in      (bcd_in),
        .load        (load),
        .blank_zeros (blank_zeros),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Advance one clock and update the model; outputs are then sampled 1 time unit later.
    task automatic step();
        int d;
        int nib;
        @(posedge clk);
        if (reset) begin
            exp_seg = 7'b1111111;
            exp_an  = 5'b11111;
            exp_fd  = 1'b0;
            value_m = 20'd0;
            cyc     = 0;
        end else begin
            d       = (cyc / DIV) % 5;
            exp_an  = 5'b11111 & ~(5'd1 << d);
            nib     = int'((value_m >> (4 * d)) & 20'hF);
            if (blank_zeros && d > 0 && (value_m >> (4 * d)) == 20'd0)
                exp_seg = 7'b1111111;
            else
                exp_seg = seg_of(nib);
            exp_fd  = (cyc > 0) && (cyc % FRAME == 0);
            if (load) value_m = bcd_in;
            cyc++;
        end
        #1;
    endtask

    task automatic test_reset();
        int pulses;
        int last_pulse;
        reset = 1'b1; load = 1'b1; bcd_in = 20'h98765; blank_zeros = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if ({seg_n, an_n, frame_done} !== {7'b1111111, 5'b11111, 1'b0}) begin
                n_err++;
                $display("FAIL reset_hold: got seg=%b an=%b fd=%b, want 1111111 11111 0", seg_n, an_n, frame_done);
            end
        end
        reset = 1'b0; load = 1'b0;
        step();
        n_vec++;
        if ({seg_n, an_n, frame_done} !== {7'b1000000, 5'b11110, 1'b0}) begin
            n_err++;
            $display("FAIL reset_first: got seg=%b an=%b fd=%b, want 1000000 11110 0", seg_n, an_n, frame_done);
        end
        for (int i = 0; i < 3; i++) step();
        n_vec++;
        if (an_n !== 5'b11110) begin
            n_err++;
            $display("FAIL slot0_len: got an=%b, want 11110", an_n);
        end
        step();
        n_vec++;
        if (an_n !== 5'b11101) begin
            n_err++;
            $display("FAIL slot1_start: got an=%b, want 11101", an_n);
        end
        pulses = 0; last_pulse = 0;
        for (int i = 6; i <= 45; i++) begin
            step();
            if (frame_done === 1'b1) begin
                n_vec++;
                if (an_n !== 5'b11110 || (pulses > 0 && i - last_pulse != FRAME)) begin
                    n_err++;
                    $display("FAIL frame_pulse: got an=%b gap=%0d at cycle %0d, want 11110 gap %0d", an_n, i - last_pulse, i, FRAME);
                end
                pulses++; last_pulse = i;
            end
        end
        n_vec++;
        if (pulses !== 2) begin
            n_err++;
            $display("FAIL frame_count: got %0d pulses, want 2", pulses);
        end
    endtask

    task automatic test_pattern(input logic [19:0] v, input logic bz, input int ncyc);
        load = 1'b1; bcd_in = v; blank_zeros = bz;
        step();
        load = 1'b0; bcd_in = $urandom;
        for (int i = 0; i < ncyc; i++) begin
            step();
            n_vec++;
            if ({seg_n, an_n, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_err++;
                $display("FAIL pattern_%h_bz%0d: got seg=%b an=%b fd=%b, want seg=%b an=%b fd=%b",
                         v, bz, seg_n, an_n, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
    endtask

    task automatic test_digits_12345();
        logic [6:0] want [5];
        logic [6:0] seen [5];
        want[0] = 7'b0010010; want[1] = 7'b0011001; want[2] = 7'b0110000;
        want[3] = 7'b0100100; want[4] = 7'b1111001;
        for (int k = 0; k < 5; k++) seen[k] = 7'bx;
        test_pattern(20'h12345, 1'b0, FRAME + DIV);
        for (int i = 0; i < FRAME; i++) begin
            step();
            for (int k = 0; k < 5; k++)
                if (an_n == (5'b11111 & ~(5'd1 << k))) seen[k] = seg_n;
        end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (seen[k] !== want[k]) begin
                n_err++;
                $display("FAIL digit12345_%0d: got seg=%b, want %b", k, seen[k], want[k]);
            end
        end
    endtask

    task automatic test_live_blank();
        test_pattern(20'h00042, 1'b1, FRAME + DIV);
        blank_zeros = 1'b0;
        for (int i = 0; i < FRAME + DIV; i++) begin
            step();
            n_vec++;
            if ({seg_n, an_n, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_err++;
                $display("FAIL live_unblank: got seg=%b an=%b, want seg=%b an=%b", seg_n, an_n, exp_seg, exp_an);
            end
        end
        test_pattern(20'h0A000, 1'b0, FRAME + DIV);
        test_pattern(20'h0A000, 1'b1, FRAME + DIV);
        test_pattern(20'h00000, 1'b1, FRAME + DIV);
    endtask

    task automatic test_load_on_tick();
        int budget;
        budget = 0;
        load = 1'b0; blank_zeros = 1'b0;
        while (!((cyc % DIV == DIV - 1) && ((cyc / DIV) % 5 == 2)) && budget < 100) begin
            step();
            budget++;
        end
        n_vec++;
        if (budget >= 100) begin
            n_err++;
            $display("FAIL tick_wait: got timeout after %0d cycles, want digit2 tick", budget);
        end
        load = 1'b1; bcd_in = 20'h99999;
        step();
        load = 1'b0;
        n_vec++;
        if (an_n !== 5'b11011 || seg_n !== exp_seg) begin
            n_err++;
            $display("FAIL tick_load_edge: got an=%b seg=%b, want an=11011 seg=%b", an_n, seg_n, exp_seg);
        end
        step();
        n_vec++;
        if (an_n !== 5'b10111 || seg_n !== 7'b0010000) begin
            n_err++;
            $display("FAIL tick_load_next: got an=%b seg=%b, want an=10111 seg=0010000", an_n, seg_n);
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            n_vec++;
            if ({seg_n, an_n, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_err++;
                $display("FAIL tick_load_after: got seg=%b an=%b fd=%b, want seg=%b an=%b fd=%b",
                         seg_n, an_n, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] v;
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 5; k++)
                v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            bcd_in = v;
            if ($urandom_range(0, 15) == 0) blank_zeros = ~blank_zeros;
            step();
            n_vec++;
            if ({seg_n, an_n, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_err++;
                $display("FAIL random_%0d: got seg=%b an=%b fd=%b, want seg=%b an=%b fd=%b",
                         i, seg_n, an_n, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1; load = 1'b1; bcd_in = 20'h55555;
        step();
        n_vec++;
        if ({seg_n, an_n, frame_done} !== {7'b1111111, 5'b11111, 1'b0}) begin
            n_err++;
            $display("FAIL midframe_reset: got seg=%b an=%b fd=%b, want 1111111 11111 0", seg_n, an_n, frame_done);
        end
        reset = 1'b0; load = 1'b0; blank_zeros = 1'b1;
        step();
        n_vec++;
        if ({seg_n, an_n} !== {7'b1000000, 5'b11110}) begin
            n_err++;
            $display("FAIL midframe_restart: got seg=%b an=%b, want 1000000 11110", seg_n, an_n);
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            n_vec++;
            if ({seg_n, an_n, frame_done} !== {exp_seg, exp_an, exp_fd}) begin
                n_err++;
                $display("FAIL midframe_after: got seg=%b an=%b fd=%b, want seg=%b an=%b fd=%b",
                         seg_n, an_n, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; bcd_in = 20'd0; blank_zeros = 1'b0;
        value_m = 20'd0; cyc = 0;
        exp_seg = 7'b1111111; exp_an = 5'b11111; exp_fd = 1'b0;
        test_reset();
        test_digits_12345();
        test_live_blank();
        test_load_on_tick();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
